passcode_checker: RTL
=====================

# passcode_checker

Passcode verification controller that sits directly downstream of the switch decoder (`full_decoder`). It consumes the decoder's two 8-bit decoded digit outputs, one digit pair per user `enter` strobe, and buffers a full passcode of `2*PAIRS` digits. It compares the buffer against a stored passcode, drives the unlocked indication and counts failed attempts with an optional timed lockout. While unlocked, it allows the stored passcode to be changed.

## Interface
- `PAIRS`, 2: number of digit pairs per passcode; passcode length is `2*PAIRS` digits.
- `MAX_FAIL`, 3: consecutive failures that trigger lockout; range 1..15.
- `LOCK_CYCLES`, 100: lockout duration in clock cycles; must be ≥1.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `num1` in 8: first decoded digit, from the decoder's `num1`.
- `num2` in 8: second decoded digit, from the decoder's `num2`.
- `enter` in 1: single-cycle strobe; samples `num1`/`num2` as one pair.
- `clear` in 1: single-cycle strobe; aborts entry or SET, or relocks from OPEN.
- `set_req` in 1: single-cycle strobe; requests a passcode change, honoured only in OPEN.
- `state` out 3: current FSM state code.
- `unlocked` out 1: high while in OPEN or SET.
- `alarm` out 1: high while in LOCKOUT.
- `fail_pulse` out 1: one-cycle pulse on each mismatch.
- `err_pulse` out 1: one-cycle pulse when a pair is rejected as invalid.
- `fail_cnt` out 4: consecutive failure count.

## Operation
- **Digit validity**
  - A pair is valid iff `num1 <= 9` and `num2 <= 9`; the values are unsigned 8-bit.
  - An invalid pair in IDLE, ENTRY or SET pulses `err_pulse`, is discarded, and leaves the index unchanged.
- **Reset values**
  - `state` = IDLE, `idx` = 0, `fail_cnt` = 0.
  - All outputs low.
  - Entry buffer cleared.
  - Stored passcode digit `k` = `(k+1) mod 10`, so with `PAIRS=2` the passcode is 1,2,3,4. Pair `j` occupies digits `2j` (`num1`) and `2j+1` (`num2`).
- **State codes**: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, SET=4, LOCKOUT=5.
- **IDLE**
  - A valid `enter` writes buffer pair 0 and sets `idx`=1.
  - Next state is CHECK if `PAIRS==1`, otherwise ENTRY.
- **ENTRY**
  - A valid `enter` writes pair `idx` and increments `idx`.
  - When `idx` reaches `PAIRS`, go to CHECK.
  - `clear` discards the buffer and returns to IDLE with `idx`=0.
- **CHECK** (exactly one cycle; all inputs ignored)
  - Match: go to OPEN and set `fail_cnt`=0.
  - Mismatch: pulse `fail_pulse` and increment `fail_cnt`.
    - If the new count equals `MAX_FAIL`, go to LOCKOUT.
    - Otherwise go to IDLE.
  - `idx` returns to 0 in either case.
- **OPEN**
  - `enter` is ignored.
  - `clear` goes to IDLE.
  - `set_req` goes to SET with `idx`=0.
- **SET**
  - Valid pairs fill a shadow buffer.
  - When the final pair is accepted, the shadow buffer is copied into the stored passcode in the same edge, and the next state is OPEN.
  - `clear` aborts the change, keeps the old passcode, and returns to OPEN.
- **LOCKOUT**
  - All inputs are ignored.
  - On entry the down-counter loads `LOCK_CYCLES-1` and decrements every cycle.
  - When the counter is 0, go to IDLE and set `fail_cnt`=0.
- **Priorities**
  - `clear` wins over `enter` and `set_req` in the same cycle.
  - `set_req` wins over `enter`.
- **Mid-operation reset**: asserting `rst_n` low in any state immediately forces the reset values, including the default passcode.

## Timing
- All outputs are registered.
- `state` reflects the transition one cycle after the sampling edge.
- Result latency: the final `enter` is sampled at edge N.
  - CHECK is occupied in the cycle N..N+1.
  - `unlocked` or `fail_pulse` is visible after edge N+1, i.e. 2 cycles after the strobe.
- `err_pulse` is high for the single cycle following the rejecting edge.
- LOCKOUT lasts exactly `LOCK_CYCLES` cycles; `alarm` is high for exactly that many cycles.
- Back-to-back `enter` strobes on consecutive cycles are accepted in IDLE, ENTRY and SET.

## Configuration
- Macro: `PASSCODE_LOCKOUT_EN`.
- **Defined**: LOCKOUT state and lockout timer are present as described above.
- **Undefined**:
  - No LOCKOUT state and no timer logic.
  - `alarm` is tied to 0.
  - `fail_cnt` saturates at `MAX_FAIL`.
  - A mismatch always returns to IDLE.

## Test plan
- Reset, then enter (1,2),(3,4) → `unlocked`=1 two cycles after the second strobe, `state`=3, `fail_cnt`=0.
- Enter (1,2),(3,5) → `fail_pulse` for one cycle, `fail_cnt`=1, `state`=0. Then enter the correct passcode → unlocked, `fail_cnt`=0.
- Three wrong passcodes with `LOCK_CYCLES=8` and `PAIRS=2` → `alarm` high exactly 8 cycles, `enter` strobes ignored during it, then `state`=0 and `fail_cnt`=0. With the macro undefined: `fail_cnt` stays at 3 and `alarm` stays 0.
- Enter (1,12) → `err_pulse`=1 for one cycle, `idx` unchanged. Then enter (1,2) with `clear` in the same cycle → `state`=0 and the buffer is discarded.
- In OPEN:
  - `set_req`, then (9,8),(7,6) → OPEN. Then `clear`, then (9,8),(7,6) → unlocked; (1,2),(3,4) now fails.
  - `set_req`, then (5,5), then `clear` → old passcode retained.
- `rst_n` pulsed low mid-ENTRY after pair 0 → `state`=0, `idx`=0, passcode restored to 1,2,3,4.

Source files
------------

// File: rtl/passcode_checker.sv
// Passcode verification controller fed by the switch decoder digit pairs.
// Define PASSCODE_LOCKOUT_EN to add the timed lockout after MAX_FAIL misses.
module passcode_checker #(
  parameter int PAIRS       = 2,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] num1,
  input  logic [7:0] num2,
  input  logic       enter,
  input  logic       clear,
  input  logic       set_req,
  output logic [2:0] state,
  output logic       unlocked,
  output logic       alarm,
  output logic       fail_pulse,
  output logic       err_pulse,
  output logic [3:0] fail_cnt
);

  localparam int DIGITS = 2 * PAIRS;
  localparam int IW = $clog2(PAIRS + 1);
  localparam logic [3:0] MAXF = 4'(MAX_FAIL);

  typedef logic [DIGITS-1:0][3:0] code_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_CHECK = 3'd2,
    S_OPEN  = 3'd3,
    S_SET   = 3'd4
`ifdef PASSCODE_LOCKOUT_EN
    ,
    S_LOCK  = 3'd5
`endif
  } state_t;

  function automatic code_t default_code();
    code_t c;
    for (int k = 0; k < DIGITS; k++) begin
      c[k] = 4'((k + 1) % 10);
    end
    return c;
  endfunction

  localparam code_t CODE_RST = default_code();

  // Pair j lands in digits 2j (num1) and 2j+1 (num2).
  function automatic code_t put_pair(
    input code_t          c,
    input logic [IW-1:0]  i,
    input logic [3:0]     d1,
    input logic [3:0]     d2
  );
    code_t r;
    r = c;
    for (int j = 0; j < PAIRS; j++) begin
      if (i == IW'(j)) begin
        r[2*j]   = d1;
        r[2*j+1] = d2;
      end
    end
    return r;
  endfunction

  state_t        cur, nxt;
  logic [IW-1:0] idx, idx_n;
  code_t         entry_buf, entry_n;
  code_t         shadow, shadow_n;
  code_t         code, code_n;
  logic [3:0]    fails, fails_n;
  logic          unl_n, fp_n, ep_n;
  logic          valid, last;

`ifdef PASSCODE_LOCKOUT_EN
  localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  logic [CW-1:0] lock_cnt, lock_n;
`endif

  always_comb begin
    nxt      = cur;
    idx_n    = idx;
    entry_n  = entry_buf;
    shadow_n = shadow;
    code_n   = code;
    fails_n  = fails;
    fp_n     = 1'b0;
    ep_n     = 1'b0;
`ifdef PASSCODE_LOCKOUT_EN
    lock_n   = lock_cnt;
`endif
    valid = (num1 <= 8'd9) && (num2 <= 8'd9);
    last  = (idx == IW'(PAIRS - 1));
    unique case (cur)
      S_IDLE, S_ENTRY: begin
        if (clear) begin
          nxt     = S_IDLE;
          idx_n   = '0;
          entry_n = '0;
        end else if (enter && !valid) begin
          ep_n = 1'b1;
        end else if (enter) begin
          entry_n = put_pair(entry_buf, idx, num1[3:0], num2[3:0]);
          idx_n   = idx + 1'b1;
          nxt     = last ? S_CHECK : S_ENTRY;
        end
      end
      S_CHECK: begin
        idx_n = '0;
        if (entry_buf == code) begin
          nxt     = S_OPEN;
          fails_n = '0;
        end else begin
          fp_n = 1'b1;
          nxt  = S_IDLE;
`ifdef PASSCODE_LOCKOUT_EN
          fails_n = fails + 1'b1;
          if (fails_n == MAXF) begin
            nxt    = S_LOCK;
            lock_n = CW'(LOCK_CYCLES - 1);
          end
`else
          if (fails != MAXF) fails_n = fails + 1'b1;
`endif
        end
      end
      S_OPEN: begin
        if (clear) begin
          nxt = S_IDLE;
        end else if (set_req) begin
          nxt   = S_SET;
          idx_n = '0;
        end
      end
      S_SET: begin
        if (clear) begin
          nxt   = S_OPEN;
          idx_n = '0;
        end else if (enter && !valid) begin
          ep_n = 1'b1;
        end else if (enter) begin
          shadow_n = put_pair(shadow, idx, num1[3:0], num2[3:0]);
          idx_n    = idx + 1'b1;
          if (last) begin
            code_n = shadow_n;
            idx_n  = '0;
            nxt    = S_OPEN;
          end
        end
      end
`ifdef PASSCODE_LOCKOUT_EN
      S_LOCK: begin
        if (lock_cnt == '0) begin
          nxt     = S_IDLE;
          fails_n = '0;
        end else begin
          lock_n = lock_cnt - 1'b1;
        end
      end
`endif
      default: begin
        nxt   = S_IDLE;
        idx_n = '0;
      end
    endcase
    unl_n = (nxt == S_OPEN) || (nxt == S_SET);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= S_IDLE;
      idx        <= '0;
      entry_buf  <= '0;
      shadow     <= '0;
      code       <= CODE_RST;
      fails      <= '0;
      unlocked   <= 1'b0;
      fail_pulse <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      cur        <= nxt;
      idx        <= idx_n;
      entry_buf  <= entry_n;
      shadow     <= shadow_n;
      code       <= code_n;
      fails      <= fails_n;
      unlocked   <= unl_n;
      fail_pulse <= fp_n;
      err_pulse  <= ep_n;
    end
  end

`ifdef PASSCODE_LOCKOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
      alarm    <= 1'b0;
    end else begin
      lock_cnt <= lock_n;
      alarm    <= (nxt == S_LOCK);
    end
  end
`else
  assign alarm = 1'b0;
`endif

  assign state    = cur;
  assign fail_cnt = fails;

endmodule
